// File: rtl/dffram_256x32_if.sv
// ============================================================================
// Module   : dffram_256x32_if
// Brief    : Single-port RAM access bus (enable, byte strobes, address, data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dffram_256x32_if #(
    parameter int WSIZE  = 4,
    parameter int AWIDTH = 8
);
    logic                  EN0;
    logic [WSIZE-1:0]      WE0;
    logic [AWIDTH-1:0]     A0;
    logic [WSIZE*8-1:0]    Di0;
    logic [WSIZE*8-1:0]    Do0;

    modport master (output EN0, WE0, A0, Di0, input Do0);
    modport slave  (input EN0, WE0, A0, Di0, output Do0);
endinterface

`default_nettype wire

// File: rtl/dffram_256x32.sv
// ============================================================================
// Module   : dffram_256x32
// Brief    : 256x32 standard-cell RAM, 16 banks of 16 words, per-byte write
//            enables, read-first registered read. Define DFFRAM_USE_LATCH_EN
//            for latch storage with CLK-gated byte enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dffram_256x32 #(
    parameter int WSIZE = 4,
    parameter int BANKS = 16
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    dffram_256x32_if.slave      bus
);
    localparam int c_BANK_WORDS = 16;
    localparam int c_BSEL_W     = $clog2(BANKS);
    localparam int AWIDTH       = c_BSEL_W + 4;
    localparam int DWIDTH       = WSIZE * 8;

    logic [c_BSEL_W-1:0] w_bank_sel;
    logic [3:0]          w_word_sel;
    logic [BANKS-1:0]    w_bank_en;
    logic [DWIDTH-1:0]   w_bank_rdata [BANKS];
    logic [DWIDTH-1:0]   r_do;

    assign w_bank_sel = bus.A0[AWIDTH-1:4];
    assign w_word_sel = bus.A0[3:0];

    // One-hot bank decode, qualified by the port enable.
    always_comb begin
        w_bank_en = '0;
        if (bus.EN0) begin
            w_bank_en[w_bank_sel] = 1'b1;
        end
    end

`ifdef DFFRAM_USE_LATCH_EN
    // Write request captured at the edge; latches open during the following low phase.
    logic [BANKS-1:0]  r_wbank;
    logic [3:0]        r_wword;
    logic [WSIZE-1:0]  r_wbe;
    logic [DWIDTH-1:0] r_wdata;

    always_ff @(posedge CLK) begin
        r_wbank <= w_bank_en;
        r_wword <= w_word_sel;
        r_wbe   <= bus.WE0;
        r_wdata <= bus.Di0;
    end
`endif

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DWIDTH-1:0] w_words [c_BANK_WORDS];

        for (genvar w = 0; w < c_BANK_WORDS; w++) begin : g_word
`ifdef DFFRAM_USE_LATCH_EN
            for (genvar y = 0; y < WSIZE; y++) begin : g_byte
                logic       w_gate;
                logic [7:0] r_byte;

                assign w_gate = ~CLK & r_wbank[b] & r_wbe[y] & (r_wword == 4'(w));

                always_latch begin
                    if (w_gate) begin
                        r_byte <= r_wdata[8*y +: 8];
                    end
                end

                assign w_words[w][8*y +: 8] = r_byte;
            end
`else
            logic              w_wsel;
            logic [DWIDTH-1:0] r_word;

            assign w_wsel = w_bank_en[b] & (w_word_sel == 4'(w));

            always_ff @(posedge CLK) begin
                for (int y = 0; y < WSIZE; y++) begin
                    if (w_wsel && bus.WE0[y]) begin
                        r_word[8*y +: 8] <= bus.Di0[8*y +: 8];
                    end
                end
            end

            assign w_words[w] = r_word;
`endif
        end

        assign w_bank_rdata[b] = w_words[w_word_sel];
    end

    // Read samples the array before this edge's write lands, giving read-first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_do <= '0;
        end else if (bus.EN0) begin
            r_do <= w_bank_rdata[w_bank_sel];
        end
    end

    assign bus.Do0 = r_do;

endmodule

`default_nettype wire

// File: tb/tb_dffram_256x32.sv
// ============================================================================
// Module   : tb_dffram_256x32
// Brief    : Randomized and directed checks of dffram_256x32 against a word
//            array reference model with per-byte known tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dffram_256x32;
    logic CLK;
    logic RST;

    dffram_256x32_if bus_if ();

    dffram_256x32 dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem   [256];
    logic [3:0]  m_known [256];
    logic [31:0] m_do;
    bit          m_do_known;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, let the edge happen, update model, check Do0.
    task automatic cycle(input bit en, input logic [3:0] we, input logic [7:0] a, input logic [31:0] d);
        bus_if.EN0 = en;
        bus_if.WE0 = we;
        bus_if.A0  = a;
        bus_if.Di0 = d;
        @(posedge CLK);
        if (en) begin
            m_do       = m_mem[a];
            m_do_known = (m_known[a] == 4'hF);
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    m_mem[a][8*i +: 8] = d[8*i +: 8];
                    m_known[a][i]      = 1'b1;
                end
            end
        end
        #1;
        if (m_do_known) check_value("do0_model", bus_if.Do0, m_do);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cycle(1'b1, 4'h0, a, 32'h0);
        check_value(tag, bus_if.Do0, exp);
    endtask

    task automatic bank_scenario(input logic [7:0] base);
        cycle(1'b1, 4'hF, base + 8'd0, 32'hAA0055BB);
        cycle(1'b1, 4'hF, base + 8'd1, 32'hAA0055CC);
        cycle(1'b1, 4'hF, base + 8'd2, 32'hAA0055DD);
        read_expect("full_word", base, 32'hAA0055BB);
        cycle(1'b1, 4'b0001, base + 8'd2, 32'h00000033);
        cycle(1'b1, 4'b0010, base + 8'd1, 32'h00003300);
        cycle(1'b1, 4'b0100, base + 8'd0, 32'h00330000);
        read_expect("mask_w0", base + 8'd0, 32'hAA3355BB);
        read_expect("mask_w1", base + 8'd1, 32'hAA0033CC);
        read_expect("mask_w2", base + 8'd2, 32'hAA005533);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] held;

        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = 32'h0;
            m_known[i] = 4'h0;
        end
        bus_if.EN0 = 1'b0;
        bus_if.WE0 = 4'h0;
        bus_if.A0  = 8'h00;
        bus_if.Di0 = 32'h0;
        RST        = 1'b1;
        m_do       = 32'h0;
        m_do_known = 1'b1;

        #1;
        check_value("reset_do0", bus_if.Do0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_value("reset_hold", bus_if.Do0, 32'h0);

        bank_scenario(8'h00);
        bank_scenario(8'h10);
        read_expect("bank0_keep_w0", 8'h00, 32'hAA3355BB);
        read_expect("bank0_keep_w1", 8'h01, 32'hAA0033CC);
        read_expect("bank0_keep_w2", 8'h02, 32'hAA005533);

        // Read-first on a same-address write.
        cycle(1'b1, 4'hF, 8'h05, 32'h12345678);
        cycle(1'b1, 4'hF, 8'h05, 32'hCAFEF00D);
        check_value("read_first", bus_if.Do0, 32'h12345678);
        read_expect("after_rdw", 8'h05, 32'hCAFEF00D);

        // Asynchronous reset mid-cycle with nonzero Do0.
        #2;
        RST = 1'b1;
        #1;
        m_do = 32'h0;
        m_do_known = 1'b1;
        check_value("async_reset", bus_if.Do0, 32'h0);
        #1;
        RST = 1'b0;
        read_expect("post_reset_rd", 8'h05, 32'hCAFEF00D);

        // Enable gating at the top address.
        cycle(1'b1, 4'hF, 8'hFF, 32'h11223344);
        read_expect("pre_en_rd", 8'h00, 32'hAA3355BB);
        held = bus_if.Do0;
        cycle(1'b0, 4'hF, 8'hFF, 32'hDEADBEEF);
        check_value("en0_hold_do", bus_if.Do0, 32'hAA3355BB);
        read_expect("en0_no_write", 8'hFF, 32'h11223344);
        cycle(1'b1, 4'hF, 8'hFF, 32'h5A5AA5A5);
        read_expect("top_addr_rw", 8'hFF, 32'h5A5AA5A5);

        // Randomized traffic, half of it concentrated on a few aliasing addresses.
        for (int n = 0; n < 600; n++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a = a & 8'h13;
            cycle($urandom_range(0, 3) != 0, 4'($urandom), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
